kp_code_rx: RTL

Receive side of the keypad link. The keypad scanner board drives a 4-bit key code plus an active-low strobe, held low for about 1 ms per key press. This block synchronizes the pins, qualifies each strobe pulse against glitches and code instability, and accepts exactly one code per pulse into a small FIFO. The safe controller drains the FIFO through a valid/ready handshake.

---
 rtl/kp_pkg.sv | 30 +++
 rtl/kp_rx_fifo.sv | 61 ++++++
 rtl/kp_code_rx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/kp_pkg.sv
// Shared types and constants for the keypad receive path.
package kp_pkg;

  localparam int unsigned KP_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUAL  = 2'd1,
    HELD  = 2'd2,
    REARM = 2'd3
  } rx_state_e;

  localparam logic [KP_CODE_W-1:0] KEY_0 = 4'h0;
  localparam logic [KP_CODE_W-1:0] KEY_1 = 4'h1;
  localparam logic [KP_CODE_W-1:0] KEY_2 = 4'h2;
  localparam logic [KP_CODE_W-1:0] KEY_3 = 4'h3;
  localparam logic [KP_CODE_W-1:0] KEY_4 = 4'h4;
  localparam logic [KP_CODE_W-1:0] KEY_5 = 4'h5;
  localparam logic [KP_CODE_W-1:0] KEY_6 = 4'h6;
  localparam logic [KP_CODE_W-1:0] KEY_7 = 4'h7;
  localparam logic [KP_CODE_W-1:0] KEY_8 = 4'h8;
  localparam logic [KP_CODE_W-1:0] KEY_9 = 4'h9;
  localparam logic [KP_CODE_W-1:0] KEY_A = 4'hA;
  localparam logic [KP_CODE_W-1:0] KEY_B = 4'hB;
  localparam logic [KP_CODE_W-1:0] KEY_C = 4'hC;
  localparam logic [KP_CODE_W-1:0] KEY_D = 4'hD;
  localparam logic [KP_CODE_W-1:0] KEY_E = 4'hE;
  localparam logic [KP_CODE_W-1:0] KEY_F = 4'hF;

endpackage

// File: rtl/kp_rx_fifo.sv
// Show-ahead key-code FIFO. A pop frees a slot in the same cycle, so a push into a
// full FIFO is accepted when it coincides with a pop. Pops while empty are ignored.
module kp_rx_fifo
  import kp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [KP_CODE_W-1:0]   push_data,
  input  logic                   pop,
  output logic [KP_CODE_W-1:0]   head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [KP_CODE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic                 do_push;
  logic                 do_pop;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;

  // Storage, pointers (natural power-of-2 wrap) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/kp_code_rx.sv
// Keypad link receiver: synchronizes the code/strobe pins, qualifies each strobe pulse
// and queues exactly one code per qualified pulse.
// Optional build macro KP_RX_STATS_EN adds saturating accept/reject counters.
module kp_code_rx
  import kp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned MIN_LOW_CYCLES  = 1000,
  parameter int unsigned MIN_HIGH_CYCLES = 1000,
  parameter int unsigned STUCK_CYCLES    = 5_000_000,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KP_CODE_W-1:0]   kp_code,
  input  logic                   kp_validn,
  output logic [KP_CODE_W-1:0]   code_data,
  output logic                   code_valid,
  input  logic                   code_ready,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic                   stuck_err,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef KP_RX_STATS_EN
  ,
  output logic [15:0]            acc_cnt,
  output logic [15:0]            rej_cnt
`endif
);

  localparam int unsigned LOW_W = $clog2(MIN_LOW_CYCLES + 1);
  localparam int unsigned HI_W  = $clog2(MIN_HIGH_CYCLES + 1);
  localparam int unsigned STK_W = $clog2(STUCK_CYCLES + 1);

  logic [SYNC_STAGES-1:0] vn_sync_q;
  logic [KP_CODE_W-1:0]   code_sync_q [SYNC_STAGES];
  logic                   vs;
  logic [KP_CODE_W-1:0]   cs;

  rx_state_e            state_q, state_d;
  logic [LOW_W-1:0]     low_cnt_q, low_cnt_d;
  logic [HI_W-1:0]      hi_cnt_q, hi_cnt_d;
  logic [STK_W-1:0]     stuck_cnt_q, stuck_cnt_d;
  logic [KP_CODE_W-1:0] cap_q, cap_d;
  logic                 stuck_err_q, stuck_err_d;
  logic                 overflow_q, overflow_d;
  logic                 accept;
  logic                 rearm_done;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 ovf_event;

  // Pin synchronizers; strobe idles high, code idles zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vn_sync_q <= '1;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        code_sync_q[i] <= '0;
      end
    end else begin
      vn_sync_q      <= {vn_sync_q[SYNC_STAGES-2:0], kp_validn};
      code_sync_q[0] <= kp_code;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        code_sync_q[i] <= code_sync_q[i-1];
      end
    end
  end

  assign vs = vn_sync_q[SYNC_STAGES-1];
  assign cs = code_sync_q[SYNC_STAGES-1];

  // Pulse qualification FSM: one accept per pulse, re-armed only by a long high period.
  always_comb begin
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    cap_d      = cap_q;
    accept     = 1'b0;
    rearm_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!vs) begin
          state_d   = QUAL;
          low_cnt_d = LOW_W'(1);
          cap_d     = cs;
        end
      end
      QUAL: begin
        if (vs) begin
          state_d = IDLE;
        end else if (cs != cap_q) begin
          cap_d     = cs;
          low_cnt_d = LOW_W'(1);
        end else if (low_cnt_q == LOW_W'(MIN_LOW_CYCLES - 1)) begin
          accept  = 1'b1;
          state_d = HELD;
        end else begin
          low_cnt_d = low_cnt_q + LOW_W'(1);
        end
      end
      HELD: begin
        if (vs) begin
          state_d  = REARM;
          hi_cnt_d = HI_W'(1);
        end
      end
      REARM: begin
        if (!vs) begin
          state_d = HELD;
        end else if (hi_cnt_q == HI_W'(MIN_HIGH_CYCLES - 1)) begin
          state_d    = IDLE;
          rearm_done = 1'b1;
        end else begin
          hi_cnt_d = hi_cnt_q + HI_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stuck detection: a low sample in IDLE/REARM always moves the FSM into QUAL/HELD,
  // so counting the whole synced-low run (cleared by any high sample) is equivalent.
  always_comb begin
    if (vs) begin
      stuck_cnt_d = '0;
    end else if (stuck_cnt_q == STK_W'(STUCK_CYCLES)) begin
      stuck_cnt_d = stuck_cnt_q;
    end else begin
      stuck_cnt_d = stuck_cnt_q + STK_W'(1);
    end
    stuck_err_d = stuck_err_q;
    if (rearm_done) begin
      stuck_err_d = 1'b0;
    end
    if (stuck_cnt_d == STK_W'(STUCK_CYCLES)) begin
      stuck_err_d = 1'b1;
    end
  end

  assign pop        = code_valid & code_ready;
  assign ovf_event  = accept & fifo_full & ~pop;

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_event) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      low_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      stuck_cnt_q <= '0;
      cap_q       <= '0;
      stuck_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      low_cnt_q   <= low_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
      cap_q       <= cap_d;
      stuck_err_q <= stuck_err_d;
      overflow_q  <= overflow_d;
    end
  end

  kp_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (cap_q),
    .pop       (code_ready),
    .head_data (code_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign code_valid = ~fifo_empty;
  assign overflow   = overflow_q;
  assign stuck_err  = stuck_err_q;

`ifdef KP_RX_STATS_EN
  logic        reject;
  logic [15:0] acc_cnt_q;
  logic [15:0] rej_cnt_q;

  assign reject = (state_q == QUAL) & vs;

  // Saturating accept/reject counters; dropped accepts still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
      rej_cnt_q <= '0;
    end else begin
      if (accept && (acc_cnt_q != '1)) begin
        acc_cnt_q <= acc_cnt_q + 16'd1;
      end
      if (reject && (rej_cnt_q != '1)) begin
        rej_cnt_q <= rej_cnt_q + 16'd1;
      end
    end
  end

  assign acc_cnt = acc_cnt_q;
  assign rej_cnt = rej_cnt_q;
`endif

endmodule
